// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if
//   Bundles the I-cache, D-cache and physical-memory sides of the pmem
//   arbiter into one interface.
//   slave  : arbiter view. Takes the cache requests and the memory response.
//            Drives the cache responses and the memory command.
//   master : environment view. Covers both caches and main memory.
//   Signals:
//     i_read, i_address, i_resp, i_rdata                  I-cache side
//     d_read, d_write, d_address, d_wdata, d_resp, d_rdata D-cache side
//     pmem_read, pmem_write, pmem_address, pmem_wdata,
//     pmem_resp, pmem_rdata                                memory side
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata,
        input  pmem_resp, pmem_rdata,
        output i_resp, i_rdata,
        output d_resp, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata,
        output pmem_resp, pmem_rdata,
        input  i_resp, i_rdata,
        input  d_resp, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares the single physical-memory port between the I-cache and the D-cache.
//   One cache-line transaction is granted at a time by a registered-grant FSM
//   (IDLE / SERVE_I / SERVE_D). The memory command is decoded from the state,
//   and the memory response strobe is routed back to the owning cache.
//   Every transaction returns to IDLE for at least one cycle, so each cache
//   sees its resp drop before the next grant.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    pmem_arbiter_if.slave (cache request/response and memory command)
//   Configuration:
//     PMEM_ARB_RR_EN  defined   : I and D requesting together -> round robin
//                     undefined : I and D requesting together -> D-cache wins
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic            clk,
    input  logic            reset,
    pmem_arbiter_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        contended_pick;
    logic              i_req;
    logic              d_req;
    logic              serve_i;
    logic              serve_d;
    logic [ADDR_W-1:0] address_sel;
    logic [LINE_W-1:0] wdata_sel;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef PMEM_ARB_RR_EN
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic last_grant;

    // last_grant is updated only when a transaction completes. A reset during
    // SERVE therefore does not count as a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_D;
        end else if (state == SERVE_I && bus.pmem_resp) begin
            last_grant <= GRANT_I;
        end else if (state == SERVE_D && bus.pmem_resp) begin
            last_grant <= GRANT_D;
        end
    end

    assign contended_pick = (last_grant == GRANT_D) ? SERVE_I : SERVE_D;
`else
    assign contended_pick = SERVE_D;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are sampled only in IDLE. Once a side is granted, the FSM stays
    // until memory responds, because memory cannot abort a transaction.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_nxt = contended_pick;
                end else if (i_req) begin
                    state_nxt = SERVE_I;
                end else if (d_req) begin
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);

    assign address_sel = serve_i ? bus.i_address :
                         serve_d ? bus.d_address : '0;
    assign wdata_sel   = serve_d ? bus.d_wdata : '0;

    // When d_read and d_write are both high, the request is treated as a write.
    // This keeps pmem_read and pmem_write mutually exclusive.
    assign bus.pmem_read    = serve_i | (serve_d & ~bus.d_write);
    assign bus.pmem_write   = serve_d & bus.d_write;
    assign bus.pmem_address = address_sel;
    assign bus.pmem_wdata   = wdata_sel;

    // Only the strobes are steered. The read line is broadcast to both caches.
    assign bus.i_resp  = serve_i & bus.pmem_resp;
    assign bus.d_resp  = serve_d & bus.pmem_resp;
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Directed bench for pmem_arbiter. A transaction-level model tracks which
//   cache owns memory. The model derives the expected memory command and
//   response routing every cycle.
//   Literal expectations pin latency, arbitration order, reset behaviour and
//   the illegal read+write case.
module tb_pmem_arbiter;

`ifdef PMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    pmem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model. owner: 0 = nobody, 1 = I-cache, 2 = D-cache.
    // last: the side that most recently completed a transaction.
    int owner  = 0;
    int last   = 2;
    bit mvalid = 1'b0;
    int grants[$];

    always @(posedge clk) begin
        if (reset) begin
            owner  = 0;
            last   = 2;
            mvalid = 1'b1;
        end else if (owner != 0) begin
            if (bus.pmem_resp) begin
                last  = owner;
                owner = 0;
            end
        end else begin
            if (bus.i_read && (bus.d_read || bus.d_write))
                owner = RR ? ((last == 1) ? 2 : 1) : 2;
            else if (bus.i_read)
                owner = 1;
            else if (bus.d_read || bus.d_write)
                owner = 2;
            if (owner != 0) grants.push_back(owner);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            logic        e_rd, e_wr;
            logic [15:0] e_addr;
            logic [127:0] e_wd;
            e_rd   = (owner == 1) || (owner == 2 && !bus.d_write);
            e_wr   = (owner == 2) && bus.d_write;
            e_addr = (owner == 1) ? bus.i_address : (owner == 2) ? bus.d_address : 16'h0;
            e_wd   = (owner == 2) ? bus.d_wdata : 128'h0;
            check("cyc_pmem_read",    bus.pmem_read,    e_rd);
            check("cyc_pmem_write",   bus.pmem_write,   e_wr);
            check("cyc_pmem_address", bus.pmem_address, e_addr);
            check("cyc_pmem_wdata",   bus.pmem_wdata,   e_wd);
            check("cyc_i_resp", bus.i_resp, (owner == 1) && bus.pmem_resp);
            check("cyc_d_resp", bus.d_resp, (owner == 2) && bus.pmem_resp);
            check("cyc_i_rdata", bus.i_rdata, bus.pmem_rdata);
            check("cyc_d_rdata", bus.d_rdata, bus.pmem_rdata);
            check("cyc_rd_wr_exclusive", bus.pmem_read & bus.pmem_write, 1'b0);
            check("cyc_resp_exclusive",  bus.i_resp & bus.d_resp, 1'b0);
        end
    end

    task automatic wait_strobe(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.pmem_read | bus.pmem_write;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no pmem strobe seen, expected one within 20 cycles", name);
        end
    endtask

    task automatic resp_on(input logic [127:0] data);
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = data;
        @(negedge clk);
    endtask

    task automatic resp_off();
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
    endtask

    // Both caches request together and hold until served.
    task automatic both_round(input int round);
        logic [15:0] first_addr, second_addr;
        first_addr  = RR ? 16'h1111 : 16'h2222;
        second_addr = RR ? 16'h2222 : 16'h1111;
        @(posedge clk); #1;
        bus.i_read = 1'b1; bus.i_address = 16'h1111;
        bus.d_read = 1'b1; bus.d_address = 16'h2222;
        wait_strobe($sformatf("t3_r%0d_first_strobe", round));
        check($sformatf("t3_r%0d_first_addr", round), bus.pmem_address, first_addr);
        resp_on(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        check($sformatf("t3_r%0d_first_i_resp", round), bus.i_resp, RR);
        check($sformatf("t3_r%0d_first_d_resp", round), bus.d_resp, !RR);
        resp_off();
        if (RR) bus.i_read = 1'b0; else bus.d_read = 1'b0;
        @(negedge clk);
        check($sformatf("t3_r%0d_bubble_read", round), bus.pmem_read, 1'b0);
        @(negedge clk);
        check($sformatf("t3_r%0d_second_read", round), bus.pmem_read, 1'b1);
        check($sformatf("t3_r%0d_second_addr", round), bus.pmem_address, second_addr);
        resp_on(128'hFEDC_BA98_7654_3210_FFEE_DDCC_BBAA_9988);
        check($sformatf("t3_r%0d_second_i_resp", round), bus.i_resp, !RR);
        check($sformatf("t3_r%0d_second_d_resp", round), bus.d_resp, RR);
        resp_off();
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int g0;
        int exp_order[4];
        logic [127:0] wline;

        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pmem_read",    bus.pmem_read,    1'b0);
        check("rst_pmem_write",   bus.pmem_write,   1'b0);
        check("rst_pmem_address", bus.pmem_address, 16'h0);
        check("rst_i_resp",       bus.i_resp,       1'b0);
        check("rst_d_resp",       bus.d_resp,       1'b0);

        // Test 1: I-cache read, one-cycle grant latency
        @(posedge clk); #1;
        reset = 1'b0;
        bus.i_read = 1'b1; bus.i_address = 16'h1230;
        @(negedge clk);
        check("t1_not_yet_read", bus.pmem_read, 1'b0);
        @(negedge clk);
        check("t1_pmem_read",    bus.pmem_read,    1'b1);
        check("t1_pmem_write",   bus.pmem_write,   1'b0);
        check("t1_pmem_address", bus.pmem_address, 16'h1230);
        repeat (2) @(posedge clk);
        resp_on(128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444);
        check("t1_i_resp", bus.i_resp, 1'b1);
        check("t1_d_resp", bus.d_resp, 1'b0);
        check("t1_i_rdata", bus.i_rdata, 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444);
        resp_off();
        bus.i_read = 1'b0;
        @(negedge clk);
        check("t1_i_resp_drop", bus.i_resp,    1'b0);
        check("t1_idle_read",   bus.pmem_read, 1'b0);

        // Test 2: D-cache writeback
        wline = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
        @(posedge clk); #1;
        bus.d_write = 1'b1; bus.d_address = 16'h8000; bus.d_wdata = wline;
        wait_strobe("t2_strobe");
        check("t2_pmem_write",   bus.pmem_write,   1'b1);
        check("t2_pmem_read",    bus.pmem_read,    1'b0);
        check("t2_pmem_address", bus.pmem_address, 16'h8000);
        check("t2_pmem_wdata",   bus.pmem_wdata,   wline);
        resp_on(128'h0);
        check("t2_d_resp", bus.d_resp, 1'b1);
        check("t2_i_resp", bus.i_resp, 1'b0);
        resp_off();
        bus.d_write = 1'b0; bus.d_wdata = '0;
        @(negedge clk);
        check("t2_idle_write", bus.pmem_write, 1'b0);

        // Test 3: contention, two rounds
        g0 = grants.size();
        both_round(0);
        both_round(1);
        if (RR) exp_order = '{1, 2, 1, 2};
        else    exp_order = '{2, 1, 2, 1};
        check("t3_grant_count", grants.size() - g0, 4);
        for (int k = 0; k < 4; k++)
            if (g0 + k < grants.size())
                check($sformatf("t3_grant_order_%0d", k), grants[g0 + k], exp_order[k]);

        // Test 4: stray pmem_resp in IDLE
        resp_on(128'h5555_5555_5555_5555_5555_5555_5555_5555);
        check("t4_i_resp", bus.i_resp, 1'b0);
        check("t4_d_resp", bus.d_resp, 1'b0);
        resp_off();
        @(negedge clk);
        check("t4_idle_read",  bus.pmem_read,  1'b0);
        check("t4_idle_write", bus.pmem_write, 1'b0);

        // Test 5: reset during SERVE_D, late response ignored
        @(posedge clk); #1;
        bus.d_read = 1'b1; bus.d_address = 16'h4000;
        wait_strobe("t5_strobe");
        check("t5_pmem_read", bus.pmem_read, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; bus.d_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        check("t5_post_rst_read",    bus.pmem_read,    1'b0);
        check("t5_post_rst_write",   bus.pmem_write,   1'b0);
        check("t5_post_rst_address", bus.pmem_address, 16'h0);
        check("t5_late_d_resp",      bus.d_resp,       1'b0);
        resp_off();

        // Test 6: illegal read+write is treated as a write
        @(posedge clk); #1;
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 16'h0040;
        wait_strobe("t6_strobe");
        check("t6_pmem_write",   bus.pmem_write,   1'b1);
        check("t6_pmem_read",    bus.pmem_read,    1'b0);
        check("t6_pmem_address", bus.pmem_address, 16'h0040);
        resp_on(128'h0);
        check("t6_d_resp", bus.d_resp, 1'b1);
        resp_off();
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
